// File: rtl/seq_ripple_borrow_subtractor_pkg.sv
// Shared definitions for the sequential ripple-borrow subtractor.
//   state_t : FSM state encoding (IDLE / BUSY / DONE)
//   clog2   : ceiling log2, used to size the slice counter
package seq_ripple_borrow_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_ripple_borrow_subtractor_borrow_cell.sv
// One-bit full subtractor: d = a - b - br_in, with borrow-out.
//   a, b    : operand bits
//   br_in   : borrow from the next-lower bit
//   d       : difference bit
//   br_out  : borrow into the next-higher bit
module borrow_cell (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/seq_ripple_borrow_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = A - B - bin over bw bits,
// one chunk-bit slice per clock (LSB slice first), borrow registered between
// slices. Valid/ready handshake on input and output.
//   CLK, RESET            : clock, asynchronous active-high reset
//   A, B, bin, in_valid   : operands, accepted when in_valid && in_ready
//   in_ready              : high in IDLE while RESET is low
//   diff, bout, ovf       : result, unsigned borrow-out, signed overflow
//   out_valid, out_ready  : result handshake; result held until accepted
module seq_ripple_borrow_subtractor
    import seq_ripple_borrow_subtractor_pkg::*;
#(
    parameter int unsigned bw    = 32,
    parameter int unsigned chunk = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [bw-1:0] A,
    input  logic [bw-1:0] B,
    input  logic          bin,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [bw-1:0] diff,
    output logic          bout,
    output logic          ovf,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned NCH = bw / chunk;
    localparam int unsigned CW  = (NCH > 1) ? clog2(NCH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [chunk-1:0] r_a_sl [NCH];
    logic [chunk-1:0] r_b_sl [NCH];
    logic [chunk-1:0] r_d_sl [NCH];
    logic [chunk-1:0] w_a_in [NCH];
    logic [chunk-1:0] w_b_in [NCH];
    logic             r_br;
    logic             r_bout;
    logic             r_ovf;
    logic             r_out_valid;
    logic [chunk-1:0] w_a;
    logic [chunk-1:0] w_b;
    logic [chunk-1:0] w_d;
    logic [chunk:0]   w_br;
    logic             w_last;

    // Operands and result are kept as slice arrays so the active slice is a
    // plain array index and each result slice is written in place.
    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign w_a_in[g]               = A[g*chunk +: chunk];
        assign w_b_in[g]               = B[g*chunk +: chunk];
        assign diff[g*chunk +: chunk]  = r_d_sl[g];
    end

    assign w_a    = r_a_sl[r_cnt];
    assign w_b    = r_b_sl[r_cnt];
    assign w_br[0] = r_br;
    assign w_last = (r_cnt == CW'(NCH - 1));

    for (genvar i = 0; i < chunk; i++) begin : g_cell
        borrow_cell u_cell (
            .a      (w_a[i]),
            .b      (w_b[i]),
            .br_in  (w_br[i]),
            .d      (w_d[i]),
            .br_out (w_br[i+1])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt       <= '0;
            r_a_sl      <= '{default: '0};
            r_b_sl      <= '{default: '0};
            r_d_sl      <= '{default: '0};
            r_br        <= 1'b0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sl <= w_a_in;
                        r_b_sl <= w_b_in;
                        r_br   <= bin;
                        r_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    r_d_sl[r_cnt] <= w_d;
                    r_br          <= w_br[chunk];
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_bout      <= w_br[chunk];
                        // Signed overflow: borrow into MSB differs from borrow out.
                        r_ovf       <= w_br[chunk-1] ^ w_br[chunk];
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !RESET;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_seq_ripple_borrow_subtractor.sv
module tb_seq_ripple_borrow_subtractor;

    logic        clk;
    logic        rst;
    logic [31:0] A, B;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] diff;
    logic        bout, ovf, out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    seq_ripple_borrow_subtractor #(.bw(32), .chunk(8)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                  output logic [31:0] d, output logic bo, output logic ov);
        logic [32:0] w;
        longint      sr;
        w  = {1'b0, a} - {1'b0, b} - {32'b0, bi};
        d  = w[31:0];
        bo = w[32];
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation from IDLE (called at a negedge) and returns the result,
    // stalling out_ready for 'stall' cycles while checking the result holds.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input int stall, output logic [31:0] d, output logic bo,
                          output logic ov, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        A = a; B = b; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        d = diff; bo = bout; ov = ovf;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            total++;
            if (diff !== d || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: diff=%h out_valid=%b, required %h 1", diff, out_valid, d);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, bout, ovf} !== 4'b0000 || diff !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b bout=%b ovf=%b diff=%h, required all 0",
                     in_ready, out_valid, bout, ovf, diff);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        bi;
        logic [31:0] d;
        logic        bo, ov;
    } vec_t;

    task automatic test_directed();
        vec_t        v[7];
        logic [31:0] d;
        logic        bo, ov;
        int          lat;
        v[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        v[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        v[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        v[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        v[4] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0};
        v[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        v[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].bi, 0, d, bo, ov, lat);
            total++;
            if (d !== v[i].d || bo !== v[i].bo || ov !== v[i].ov) begin
                bad++;
                $display("FAIL directed[%0d]: diff=%h bout=%b ovf=%b, required %h %b %b",
                         i, d, bo, ov, v[i].d, v[i].bo, v[i].ov);
            end
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL latency[%0d]: %0d cycles, required 4", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed;
        logic        ebo, eov;
        int          n;
        model(32'h1234_0000, 32'h0000_5678, 1'b0, ed, ebo, eov);
        A = 32'h1234_0000; B = 32'h0000_5678; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; bin = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || diff !== ed || bout !== ebo || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b diff=%h bout=%b in_ready=%b, required 1 %h %b 0",
                         i, out_valid, diff, bout, in_ready, ed, ebo);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic        ebo, eov;
        int          n;
        model(32'h0000_1000, 32'h0000_0FFF, 1'b1, ed, ebo, eov);
        A = 32'h0000_0007; B = 32'h0000_0009; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        // Output handshake and a new request on the same edge.
        out_ready = 1'b1;
        A = 32'h0000_1000; B = 32'h0000_0FFF; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_no_same_edge_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept_next_edge: in_ready=%b, required 0", in_ready);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 4 || diff !== ed || bout !== ebo || ovf !== eov) begin
            bad++;
            $display("FAIL b2b_result: lat=%0d diff=%h bout=%b ovf=%b, required 4 %h %b %b",
                     n, diff, bout, ovf, ed, ebo, eov);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] d, ed;
        logic        bo, ov, ebo, eov;
        int          lat;
        A = 32'h1234_5678; B = 32'h0101_0101; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || diff !== 32'h0 || in_ready !== 1'b0 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy: out_valid=%b diff=%h in_ready=%b bout=%b ovf=%b, required 0 0 0 0 0",
                     out_valid, diff, in_ready, bout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_stale[%0d]: out_valid=%b, required 0", i, out_valid);
            end
        end
        model(32'hCAFE_0000, 32'h0000_0001, 1'b1, ed, ebo, eov);
        run_op(32'hCAFE_0000, 32'h0000_0001, 1'b1, 0, d, bo, ov, lat);
        total++;
        if (d !== ed || bo !== ebo || ov !== eov) begin
            bad++;
            $display("FAIL reset_recover: diff=%h bout=%b ovf=%b, required %h %b %b", d, bo, ov, ed, ebo, eov);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, ed;
        logic        bi, bo, ov, ebo, eov;
        int          lat, stall;
        for (int i = 0; i < 3000; i++) begin
            a = pick();
            b = pick();
            bi = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            model(a, b, bi, ed, ebo, eov);
            run_op(a, b, bi, stall, d, bo, ov, lat);
            total++;
            if (d !== ed || bo !== ebo || ov !== eov || lat !== 4) begin
                bad++;
                $display("FAIL random[%0d] A=%h B=%h bin=%b: diff=%h bout=%b ovf=%b lat=%0d, required %h %b %b 4",
                         i, a, b, bi, d, bo, ov, lat, ed, ebo, eov);
            end
        end
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
